// File: rtl/neureka_tcdm_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : neureka_tcdm_aggregator
// Description : Splits one wide TCDM transaction into MP 32-bit narrow port
//               requests, tracks per-port grants and read responses, and
//               returns the reassembled wide read data. One wide transaction
//               is in flight at a time.
//               Optional build macro NEUREKA_AGG_BE_SKIP_EN: ports whose
//               byte-enable slice is all zero are not requested, count as
//               granted and read back as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module neureka_tcdm_aggregator #(
    parameter int MP = 9,
    parameter int BW = MP * 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wide_req_i,
    output logic                wide_gnt_o,
    input  logic [31:0]         wide_add_i,
    input  logic                wide_wen_i,
    input  logic [BW/8-1:0]     wide_be_i,
    input  logic [BW-1:0]       wide_data_i,
    output logic [BW-1:0]       wide_r_data_o,
    output logic                wide_r_valid_o,
    output logic [MP-1:0]       tcdm_req_o,
    output logic [MP-1:0][31:0] tcdm_add_o,
    output logic [MP-1:0]       tcdm_wen_o,
    output logic [MP-1:0][3:0]  tcdm_be_o,
    output logic [MP-1:0][31:0] tcdm_data_o,
    input  logic [MP-1:0]       tcdm_gnt_i,
    input  logic [MP-1:0][31:0] tcdm_r_data_i,
    input  logic [MP-1:0]       tcdm_r_valid_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_add;
    logic                r_wen;
    logic [BW/8-1:0]     r_be;
    logic [BW-1:0]       r_data;
    logic [MP-1:0]       r_en_mask;   // ports taking part in the current transaction
    logic [MP-1:0]       r_gnt_mask;  // ports already granted while in ISSUE
    logic [MP-1:0]       r_pend;      // read ports granted, response not yet seen
    logic [MP-1:0]       r_rv_mask;   // read ports whose response is buffered
    logic [MP-1:0][31:0] r_buf;

    logic [31:0]         w_src_add;
    logic                w_src_wen;
    logic [BW/8-1:0]     w_src_be;
    logic [BW-1:0]       w_src_data;
    logic [MP-1:0]       w_en_in;
    logic [MP-1:0]       w_en_lat;
    logic [MP-1:0]       w_req;
    logic [MP-1:0]       w_granted;
    logic                w_all_gnt;
    logic [MP-1:0]       w_rv_hit;
    logic [MP-1:0]       w_rv_next;
    logic                w_start;

    assign w_start   = (r_state == S_IDLE) && wide_req_i;
    assign w_granted = w_req & tcdm_gnt_i;
    assign w_all_gnt = ((w_req & ~tcdm_gnt_i) == '0);
    assign w_rv_hit  = r_pend & tcdm_r_valid_i;
    assign w_rv_next = r_rv_mask | w_rv_hit;

    assign wide_gnt_o     = (w_start || (r_state == S_ISSUE)) && w_all_gnt;
    assign wide_r_valid_o = (r_state == S_RESP);
    assign wide_r_data_o  = (r_state == S_RESP) ? r_buf : '0;

    // Narrow request side: live wide inputs in IDLE, latched copy in ISSUE
    always_comb begin
        w_src_add  = (r_state == S_IDLE) ? wide_add_i  : r_add;
        w_src_wen  = (r_state == S_IDLE) ? wide_wen_i  : r_wen;
        w_src_be   = (r_state == S_IDLE) ? wide_be_i   : r_be;
        w_src_data = (r_state == S_IDLE) ? wide_data_i : r_data;
        w_en_in    = '1;
        w_en_lat   = '1;
        for (int ii = 0; ii < MP; ii++) begin
`ifdef NEUREKA_AGG_BE_SKIP_EN
            w_en_in[ii]  = |wide_be_i[4*ii +: 4];
            w_en_lat[ii] = |r_be[4*ii +: 4];
`else
            w_en_in[ii]  = 1'b1;
            w_en_lat[ii] = 1'b1;
`endif
        end
        case (r_state)
            S_IDLE:  w_req = wide_req_i ? w_en_in : '0;
            S_ISSUE: w_req = w_en_lat & ~r_gnt_mask;
            default: w_req = '0;
        endcase
        for (int ii = 0; ii < MP; ii++) begin
            tcdm_req_o[ii]  = w_req[ii];
            tcdm_add_o[ii]  = w_req[ii] ? (w_src_add + 32'(4 * ii)) : 32'h0;
            tcdm_wen_o[ii]  = w_req[ii] & w_src_wen;
            tcdm_be_o[ii]   = w_req[ii] ? w_src_be[4*ii +: 4] : 4'h0;
            tcdm_data_o[ii] = w_req[ii] ? w_src_data[32*ii +: 32] : 32'h0;
        end
    end

    // Transaction FSM, grant tracking and response capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_add      <= '0;
            r_wen      <= 1'b0;
            r_be       <= '0;
            r_data     <= '0;
            r_en_mask  <= '0;
            r_gnt_mask <= '0;
            r_pend     <= '0;
            r_rv_mask  <= '0;
            r_buf      <= '0;
        end else begin
            // Responses are accepted in any state, only on ports awaiting one
            for (int ii = 0; ii < MP; ii++) begin
                if (w_rv_hit[ii]) begin
                    r_buf[ii] <= tcdm_r_data_i[ii];
                end
            end
            r_rv_mask <= w_rv_next;
            r_pend    <= (r_pend & ~tcdm_r_valid_i) | (w_src_wen ? w_granted : '0);

            case (r_state)
                S_IDLE: begin
                    if (wide_req_i) begin
                        r_add     <= wide_add_i;
                        r_wen     <= wide_wen_i;
                        r_be      <= wide_be_i;
                        r_data    <= wide_data_i;
                        r_en_mask <= w_en_in;
                        if (w_all_gnt) begin
                            r_gnt_mask <= '0;
                            if (wide_wen_i) begin
                                // Nothing to wait for when every port is skipped
                                r_state <= (w_en_in == '0) ? S_RESP : S_WAIT;
                            end
                        end else begin
                            r_gnt_mask <= w_granted;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_gnt_mask <= r_gnt_mask | w_granted;
                    if (w_all_gnt) begin
                        r_gnt_mask <= '0;
                        r_state    <= r_wen ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if ((w_rv_next & r_en_mask) == r_en_mask) begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rv_mask <= '0;
                    r_buf     <= '0;
                    r_pend    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neureka_tcdm_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_neureka_tcdm_aggregator
// Description : Self-checking bench for neureka_tcdm_aggregator. The bench
//               plays the TCDM slaves (grant, one-cycle read response) on top
//               of a word memory model and predicts the wide behaviour.
//               Honours NEUREKA_AGG_BE_SKIP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neureka_tcdm_aggregator;

    localparam int MP  = 9;
    localparam int BW  = MP * 32;
    localparam int BEW = BW / 8;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                wide_req_i;
    logic                wide_gnt_o;
    logic [31:0]         wide_add_i;
    logic                wide_wen_i;
    logic [BEW-1:0]      wide_be_i;
    logic [BW-1:0]       wide_data_i;
    logic [BW-1:0]       wide_r_data_o;
    logic                wide_r_valid_o;
    logic [MP-1:0]       tcdm_req_o;
    logic [MP-1:0][31:0] tcdm_add_o;
    logic [MP-1:0]       tcdm_wen_o;
    logic [MP-1:0][3:0]  tcdm_be_o;
    logic [MP-1:0][31:0] tcdm_data_o;
    logic [MP-1:0]       tcdm_gnt_i;
    logic [MP-1:0][31:0] tcdm_r_data_i;
    logic [MP-1:0]       tcdm_r_valid_i;

    always #5 clk = ~clk;

    neureka_tcdm_aggregator #(.MP(MP), .BW(BW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wide_req_i     (wide_req_i),
        .wide_gnt_o     (wide_gnt_o),
        .wide_add_i     (wide_add_i),
        .wide_wen_i     (wide_wen_i),
        .wide_be_i      (wide_be_i),
        .wide_data_i    (wide_data_i),
        .wide_r_data_o  (wide_r_data_o),
        .wide_r_valid_o (wide_r_valid_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_wen_o     (tcdm_wen_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_data_o    (tcdm_data_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_r_data_i  (tcdm_r_data_i),
        .tcdm_r_valid_i (tcdm_r_valid_i)
    );

    int total = 0;
    int bad   = 0;
    bit [31:0] mem [bit [31:0]];

`ifdef NEUREKA_AGG_BE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ports taking part in a transaction with these byte enables
    function automatic logic [MP-1:0] en_of(input logic [BEW-1:0] be);
        logic [MP-1:0] en;
        for (int ii = 0; ii < MP; ii++) en[ii] = !SKIP || (|be[4*ii +: 4]);
        return en;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic drive_resp(input logic [MP-1:0] v, input logic [31:0] add);
        for (int ii = 0; ii < MP; ii++) begin
            tcdm_r_valid_i[ii] = v[ii];
            tcdm_r_data_i[ii]  = v[ii] ? mem_rd(add + 32'(4 * ii)) : 32'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ":req"},  tcdm_req_o,  '0);
        chk({tag, ":add"},  tcdm_add_o,  '0);
        chk({tag, ":wen"},  tcdm_wen_o,  '0);
        chk({tag, ":be"},   tcdm_be_o,   '0);
        chk({tag, ":data"}, tcdm_data_o, '0);
        chk({tag, ":gnt"},  wide_gnt_o,  '0);
        chk({tag, ":rv"},   wide_r_valid_o, '0);
    endtask

    // One wide transaction; starts and ends on a falling edge.
    // mode 0: all grants, 1: random grants, 2: port 3 held off 3 cycles
    task automatic run_txn(input string nm, input logic wen, input logic [31:0] add,
                           input logic [BEW-1:0] be, input logic [BW-1:0] data, input int mode);
        logic [MP-1:0]       en, granted, prev, g, exp_req;
        logic [MP-1:0][31:0] e_add, e_data;
        logic [MP-1:0][3:0]  e_be;
        logic [BW-1:0]       exp_rd;
        logic [31:0]         w;
        bit                  done;
        int                  cyc, lat;
        en = en_of(be);
        granted = '0; prev = '0; done = 1'b0; cyc = 0;
        for (int ii = 0; ii < MP; ii++)
            exp_rd[32*ii +: 32] = en[ii] ? mem_rd(add + 32'(4 * ii)) : 32'h0;
        lat = (en == '0) ? 1 : 2;
        wide_req_i = 1'b1; wide_add_i = add; wide_wen_i = wen;
        wide_be_i = be; wide_data_i = data;
        while (!done) begin
            for (int ii = 0; ii < MP; ii++) begin
                case (mode)
                    0:       g[ii] = 1'b1;
                    1:       g[ii] = 1'($urandom_range(0, 1));
                    default: g[ii] = (ii != 3) || (cyc >= 3);
                endcase
            end
            tcdm_gnt_i = g;
            drive_resp(wen ? prev : '0, add);
            #1;
            exp_req = en & ~granted;
            for (int ii = 0; ii < MP; ii++) begin
                e_add[ii]  = exp_req[ii] ? add + 32'(4 * ii) : 32'h0;
                e_be[ii]   = exp_req[ii] ? be[4*ii +: 4] : 4'h0;
                e_data[ii] = exp_req[ii] ? data[32*ii +: 32] : 32'h0;
            end
            chk({nm, ":req"},  tcdm_req_o,  exp_req);
            chk({nm, ":add"},  tcdm_add_o,  e_add);
            chk({nm, ":be"},   tcdm_be_o,   e_be);
            chk({nm, ":data"}, tcdm_data_o, e_data);
            chk({nm, ":wen"},  tcdm_wen_o,  wen ? exp_req : '0);
            chk({nm, ":gnt"},  wide_gnt_o,  ((exp_req & ~g) == '0));
            chk({nm, ":rv_busy"}, wide_r_valid_o, 1'b0);
            done = ((exp_req & ~g) == '0);
            prev = exp_req & g;
            granted |= prev;
            cyc++;
            if (!done && cyc >= 100) begin
                chk({nm, ":gnt_timeout"}, 1'b1, 1'b0);
                done = 1'b1;
            end
            @(negedge clk);
        end
        wide_req_i = 1'b0;
        if (!wen) begin
            for (int ii = 0; ii < MP; ii++) begin
                if (en[ii]) begin
                    w = mem_rd(add + 32'(4 * ii));
                    for (int b = 0; b < 4; b++)
                        if (be[4*ii + b]) w[8*b +: 8] = data[32*ii + 8*b +: 8];
                    mem[add + 32'(4 * ii)] = w;
                end
            end
        end
        for (int k = 1; k <= 4; k++) begin
            tcdm_gnt_i = MP'($urandom);
            drive_resp((k == 1) ? prev : '0, add);
            #1;
            chk({nm, ":req_idle"}, tcdm_req_o, '0);
            chk({nm, ":gnt_idle"}, wide_gnt_o, 1'b0);
            chk({nm, ":rv"}, wide_r_valid_o, (wen && k == lat));
            if (wen && k == lat) chk({nm, ":rdata"}, wide_r_data_o, exp_rd);
            @(negedge clk);
        end
        tcdm_r_valid_i = '0;
        tcdm_gnt_i     = '0;
    endtask

    initial begin
        logic [BEW-1:0] be;
        logic [BW-1:0]  d;
        rst_i = 1'b1; wide_req_i = 1'b0; wide_add_i = '0; wide_wen_i = 1'b0;
        wide_be_i = '0; wide_data_i = '0; tcdm_gnt_i = '0;
        tcdm_r_data_i = '0; tcdm_r_valid_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        chk("reset:rdata", wide_r_data_o, '0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Full-grant read at 0x100
        for (int ii = 0; ii < BW; ii += 32) d[ii +: 32] = 32'($urandom);
        run_txn("rd100", 1'b1, 32'h100, '1, d, 0);

        // Write with port 3 grant held off, then read it back
        for (int ii = 0; ii < BW; ii += 32) d[ii +: 32] = 32'($urandom);
        run_txn("wr_p3", 1'b0, 32'h200, '1, d, 2);
        run_txn("rd200", 1'b1, 32'h200, '1, d, 1);

        // Address wrap at the top of the space
        run_txn("wrap", 1'b1, 32'hFFFF_FFF8, '1, d, 0);

        // Read with byte-enable slice 5 cleared
        be = '1; be[20 +: 4] = 4'h0;
        run_txn("be5", 1'b1, 32'h300, be, d, 1);

        // All byte enables cleared, read then write
        run_txn("be0_rd", 1'b1, 32'h400, '0, d, 0);
        run_txn("be0_wr", 1'b0, 32'h400, '0, d, 0);

        // Spurious response on port 0 while idle
        tcdm_r_valid_i = MP'(1); tcdm_r_data_i[0] = 32'hDEAD_BEEF;
        #1;
        check_quiet("spur");
        @(negedge clk);
        tcdm_r_valid_i = '0;
        #1;
        check_quiet("spur_after");
        @(negedge clk);
        run_txn("post_spur", 1'b1, 32'h500, '1, d, 0);

        // Reset while waiting for read responses, then late responses
        wide_req_i = 1'b1; wide_wen_i = 1'b1; wide_add_i = 32'h600;
        wide_be_i = '1; tcdm_gnt_i = '1;
        #1;
        chk("rstwait:gnt", wide_gnt_o, 1'b1);
        @(negedge clk);
        wide_req_i = 1'b0; tcdm_gnt_i = '0; rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        drive_resp('1, 32'h600);
        #1;
        check_quiet("rstwait_late");
        @(negedge clk);
        tcdm_r_valid_i = '0;
        #1;
        check_quiet("rstwait_after");
        chk("rstwait:rdata", wide_r_data_o, '0);
        @(negedge clk);
        run_txn("post_rst", 1'b1, 32'h600, '1, d, 1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int ii = 0; ii < MP; ii++)
                be[4*ii +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            for (int ii = 0; ii < BW; ii += 32) d[ii +: 32] = 32'($urandom);
            run_txn("rand", 1'($urandom_range(0, 1)), 32'($urandom), be, d, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neureka_tcdm_aggregator.md
NEUREKA_TCDM_AGGREGATOR -- requirements
Module: neureka_tcdm_aggregator

Interface
REQ-001 SHALL have parameter MP, default 9, giving the number of 32-bit narrow TCDM ports.
REQ-002 SHALL have parameter BW, default MP*32, giving the wide data width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wide_req_i, input, 1 bit: wide request.
REQ-006 SHALL have port wide_gnt_o, output, 1 bit: wide grant.
REQ-007 SHALL have port wide_add_i, input, 32 bits: byte base address.
REQ-008 SHALL have port wide_wen_i, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have port wide_be_i, input, BW/8 bits: byte enables.
REQ-010 SHALL have port wide_data_i, input, BW bits: write data.
REQ-011 SHALL have port wide_r_data_o, output, BW bits: read data.
REQ-012 SHALL have port wide_r_valid_o, output, 1 bit: read data valid.
REQ-013 SHALL have ports tcdm_req_o [MP], tcdm_add_o [MP][32], tcdm_wen_o [MP], tcdm_be_o [MP][4] and tcdm_data_o [MP][32], all outputs, forming the narrow request side.
REQ-014 SHALL have ports tcdm_gnt_i [MP], tcdm_r_data_i [MP][32] and tcdm_r_valid_i [MP], all inputs, forming the narrow response side.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP, allowing exactly one wide transaction in flight.
REQ-016 In IDLE with wide_req_i=1, SHALL drive all enabled ports combinationally from the wide inputs and record the granted ports in gnt_mask.
REQ-017 If every enabled port is granted in the same cycle, SHALL assert wide_gnt_o in that cycle and go to WAIT for a read or stay in IDLE for a write.
REQ-018 If any enabled port is not granted, SHALL latch add/wen/be/data, keep wide_gnt_o=0 and go to ISSUE.
REQ-019 In ISSUE, SHALL request only the ungranted ports, using the latched values.
REQ-020 In ISSUE, SHALL assert wide_gnt_o in the cycle the last pending port is granted, then go to WAIT (read) or IDLE (write).
REQ-021 Per port, tcdm_add_o[ii] SHALL equal (add + 4*ii) mod 2^32; wrap-around SHALL be silent.
REQ-022 Per port, tcdm_be_o[ii] and tcdm_data_o[ii] SHALL carry slice ii of the wide be/data.
REQ-023 Per port, tcdm_req_o[ii] SHALL drop in the cycle after that port is granted.
REQ-024 The response on tcdm_r_valid_i[ii] SHALL be taken to arrive one cycle after that port's grant, and SHALL be captured into slice ii of the response buffer, setting bit ii of rv_mask.
REQ-025 Responses SHALL be captured in whichever state they arrive, including ISSUE.
REQ-026 When rv_mask covers all enabled ports, including arrivals in the same cycle, SHALL go to RESP.
REQ-027 In RESP, SHALL assert wide_r_valid_o for exactly one cycle with the registered buffer, then return to IDLE.
REQ-028 Wide read latency SHALL be: last grant at t -> wide_r_valid_o at t+2.
REQ-029 wide_gnt_o SHALL be 0 in WAIT and RESP.
REQ-030 A write SHALL never produce wide_r_valid_o.
REQ-031 An r_valid on a port with no pending response SHALL be ignored.
REQ-032 Narrow request outputs SHALL be 0 whenever tcdm_req_o[ii]=0.

Reset
REQ-033 While rst_i=1 at a clock edge, SHALL enter IDLE and clear gnt_mask, rv_mask, the latches and the buffer.
REQ-034 After reset, all outputs SHALL be 0.
REQ-035 Reset in the middle of a transaction SHALL abort it; narrow responses still in flight SHALL be dropped and SHALL NOT raise wide_r_valid_o.

Configuration
REQ-036 Macro NEUREKA_AGG_BE_SKIP_EN SHALL select whether ports with zero byte enables are skipped.
REQ-037 With NEUREKA_AGG_BE_SKIP_EN defined, a port with be slice == 0 SHALL NOT be requested, SHALL count as granted, and for reads SHALL return slice 0 in wide_r_data_o.
REQ-038 With NEUREKA_AGG_BE_SKIP_EN defined and all be == 0, wide_gnt_o SHALL assert in the cycle of the request; for a read, wide_r_valid_o SHALL assert 1 cycle later.
REQ-039 Without NEUREKA_AGG_BE_SKIP_EN, all MP ports SHALL always be requested regardless of be.

Verification
REQ-040 All gnt=1, read at add 0x100 with MP=9 -> tcdm_add_o = 0x100..0x120 step 4, wide_gnt_o in the same cycle, wide_r_valid_o 2 cycles later, data equal to the concatenated port words.
REQ-041 Port 3 grant delayed 3 cycles on a write -> wide_gnt_o only in the cycle port 3 is granted, ports 0-2 and 4-8 requested exactly once, no wide_r_valid_o.
REQ-042 add 0xFFFFFFF8 -> port 2 address 0x00000000.
REQ-043 rst_i pulsed while in WAIT, followed by late narrow r_valid pulses -> outputs 0, no wide_r_valid_o, next request served normally.
REQ-044 NEUREKA_AGG_BE_SKIP_EN defined, be slice 5 = 0 on a read -> tcdm_req_o[5] never asserted, wide_r_data_o slice 5 = 0.
REQ-045 Spurious tcdm_r_valid_i[0] in IDLE -> no state change, no wide_r_valid_o.
